// File: rtl/simd_pkg.sv
// Shared SIMD vector-unit definitions: default operand geometry and the matrix element type.
package simd_pkg;

  localparam int WIDTH_V     = 128;
  localparam int BITS_INDEX  = 8;
  localparam int MATRIX_SIZE = 4;

  typedef logic [BITS_INDEX-1:0] elem_t;

endpackage

// File: rtl/dot_product_lane.sv
// One output element of C: row of A dotted with column of B, wrapped to BITS_INDEX bits.
module dot_product_lane #(
  parameter int BITS_INDEX  = simd_pkg::BITS_INDEX,
  parameter int MATRIX_SIZE = simd_pkg::MATRIX_SIZE
) (
  input  logic [MATRIX_SIZE*BITS_INDEX-1:0] row,
  input  logic [MATRIX_SIZE*BITS_INDEX-1:0] col,
  output logic [BITS_INDEX-1:0]             sum
);
  import simd_pkg::*;

  // Only the low BITS_INDEX bits of each product can reach the wrapped sum.
  always_comb begin
    logic [2*BITS_INDEX-1:0] prod;
    prod = '0;
    sum  = '0;
    for (int unsigned k = 0; k < MATRIX_SIZE; k++) begin
      prod = {{BITS_INDEX{1'b0}}, row[k*BITS_INDEX +: BITS_INDEX]} *
             {{BITS_INDEX{1'b0}}, col[k*BITS_INDEX +: BITS_INDEX]};
      sum  = sum + prod[BITS_INDEX-1:0];
    end
  end

endmodule

// File: rtl/dot_product.sv
// Matrix product C = A x B on flattened NxN operands, wrapped per element, one register stage.
module dot_product #(
  parameter int WIDTH_V     = simd_pkg::WIDTH_V,
  parameter int BITS_INDEX  = simd_pkg::BITS_INDEX,
  parameter int MATRIX_SIZE = simd_pkg::MATRIX_SIZE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH_V-1:0] a,
  input  logic [WIDTH_V-1:0] b,
  output logic [WIDTH_V-1:0] result,
  output logic               out_valid
);
  import simd_pkg::*;

  localparam int ROW_W = MATRIX_SIZE * BITS_INDEX;

  if (MATRIX_SIZE * MATRIX_SIZE * BITS_INDEX != WIDTH_V) begin : g_bad_cfg
    $fatal(1, "dot_product: MATRIX_SIZE^2 * BITS_INDEX must equal WIDTH_V");
  end

  logic [ROW_W-1:0]   col_bus [MATRIX_SIZE];
  logic [WIDTH_V-1:0] c_next;

  // Rows of A are contiguous slices; columns of B are strided and gathered here.
  always_comb begin
    for (int unsigned j = 0; j < MATRIX_SIZE; j++) begin
      col_bus[j] = '0;
      for (int unsigned k = 0; k < MATRIX_SIZE; k++) begin
        col_bus[j][k*BITS_INDEX +: BITS_INDEX] = b[(k*MATRIX_SIZE + j)*BITS_INDEX +: BITS_INDEX];
      end
    end
  end

  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_row
    for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
      dot_product_lane #(
        .BITS_INDEX  (BITS_INDEX),
        .MATRIX_SIZE (MATRIX_SIZE)
      ) u_lane (
        .row (a[i*ROW_W +: ROW_W]),
        .col (col_bus[j]),
        .sum (c_next[(i*MATRIX_SIZE + j)*BITS_INDEX +: BITS_INDEX])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) result <= c_next;
    end
  end

endmodule

// File: tb/tb_dot_product.sv
// Self-checking bench for dot_product against a plain-arithmetic matrix multiply model.
module tb_dot_product;
  import simd_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] a;
  logic [127:0] b;
  logic [127:0] result;
  logic         out_valid;

  int tests;
  int fails;

  dot_product #(
    .WIDTH_V     (128),
    .BITS_INDEX  (8),
    .MATRIX_SIZE (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .result    (result),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] model(input logic [127:0] ma, input logic [127:0] mb);
    int    am [4][4];
    int    bm [4][4];
    int    s;
    elem_t e;
    logic [127:0] c;
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 4; q++) begin
        am[r][q] = int'(ma[(r*4+q)*8 +: 8]);
        bm[r][q] = int'(mb[(r*4+q)*8 +: 8]);
      end
    c = '0;
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 4; q++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += am[r][k] * bm[k][q];
        e = elem_t'(s % 256);
        c[(r*4+q)*8 +: 8] = e;
      end
    return c;
  endfunction

  function automatic logic [127:0] pack(input int e [16]);
    logic [127:0] v;
    v = '0;
    for (int n = 0; n < 16; n++) v[n*8 +: 8] = elem_t'(e[n]);
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] splat(input int val);
    logic [127:0] v;
    for (int n = 0; n < 16; n++) v[n*8 +: 8] = elem_t'(val);
    return v;
  endfunction

  // Drives a cycle's inputs after a falling edge and returns at the next falling edge.
  task automatic drive(input logic v, input logic [127:0] da, input logic [127:0] db);
    in_valid = v;
    a        = da;
    b        = db;
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [127:0] exp_r, input logic exp_v);
    tests++;
    if (result !== exp_r) begin
      fails++;
      $display("FAIL %s result: got %h want %h", name, result, exp_r);
    end
    tests++;
    if (out_valid !== exp_v) begin
      fails++;
      $display("FAIL %s out_valid: got %b want %b", name, out_valid, exp_v);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, rnd128(), rnd128());
      tests++;
      if (result !== '0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: got result=%h out_valid=%b want 0/0", result, out_valid);
      end
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    drive(1'b0, rnd128(), rnd128());
    tests++;
    if (out_valid !== 1'b0 || result !== '0) begin
      fails++;
      $display("FAIL reset_release_idle: got result=%h out_valid=%b want 0/0", result, out_valid);
    end
  endtask

  task automatic test_uniform();
    drive(1'b1, splat(2), splat(3));
    check("uniform", splat(24), 1'b1);
  endtask

  task automatic test_mixed();
    int ea [16] = '{6,3,1,0, 2,3,5,8, 6,2,5,1, 5,2,4,2};
    int eb [16] = '{2,2,2,2, 1,4,1,4, 1,0,1,0, 0,1,0,1};
    int ec [16] = '{16,24,16,24, 12,24,12,24, 19,21,19,21, 16,20,16,20};
    drive(1'b1, pack(ea), pack(eb));
    check("mixed", pack(ec), 1'b1);
  endtask

  task automatic test_wrap();
    drive(1'b1, splat(255), splat(255));
    check("wrap_ff", splat(4), 1'b1);
    drive(1'b1, splat(16), splat(16));
    check("wrap_zero", '0, 1'b1);
  endtask

  task automatic test_identity();
    logic [127:0] id;
    logic [127:0] r;
    id = '0;
    for (int n = 0; n < 4; n++) id[(n*5)*8 +: 8] = 8'd1;
    r = rnd128();
    drive(1'b1, r, id);
    check("identity_b", r, 1'b1);
    r = rnd128();
    drive(1'b1, id, r);
    check("identity_a", r, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [127:0] pa [3];
    logic [127:0] pb [3];
    logic [127:0] last;
    for (int n = 0; n < 3; n++) begin
      pa[n] = rnd128();
      pb[n] = rnd128();
      drive(1'b1, pa[n], pb[n]);
      check($sformatf("b2b_%0d", n), model(pa[n], pb[n]), 1'b1);
    end
    last = model(pa[2], pb[2]);
    drive(1'b0, rnd128(), rnd128());
    check("hold_random_ab", last, 1'b0);
    drive(1'b0, 'x, 'x);
    check("hold_x_ab", last, 1'b0);
  endtask

  task automatic test_random();
    logic [127:0] exp_r;
    logic [127:0] ra;
    logic [127:0] rb;
    logic         v;
    int           nvalid;
    exp_r  = result;
    nvalid = 0;
    while (nvalid < 1000) begin
      v  = ($urandom_range(0, 3) != 0);
      ra = rnd128();
      rb = rnd128();
      if (v) begin
        exp_r = model(ra, rb);
        nvalid++;
      end
      drive(v, ra, rb);
      check("random", exp_r, v);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, splat(1), splat(1));
    check("pre_async", splat(4), 1'b1);
    in_valid = 1'b1;
    a        = splat(3);
    b        = splat(3);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (result !== '0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got result=%h out_valid=%b want 0/0", result, out_valid);
    end
    @(negedge clk);
    check("reset_discard", '0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, rnd128(), rnd128());
    check("post_reset_idle", '0, 1'b0);
    drive(1'b1, splat(1), splat(2));
    check("post_reset_first", splat(8), 1'b1);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    @(negedge clk);
    test_reset();
    test_uniform();
    test_mixed();
    test_wrap();
    test_identity();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
